vga_sync_pipe: RTL and testbench
================================

# vga_sync_pipe

Parametrised VGA timing generator that succeeds the basic sync block. It keeps free-running column/row counters for the front end's pixel fetch and adds several controls:
- a configurable delay line, so `visible`/`hsync`/`vsync` line up with the pixel-data latency of the fetch path;
- configurable sync polarities;
- line/frame start strobes and a vertical-blank flag.

It sits between the pixel clock domain's top level and the framebuffer read pipeline.

## Interface
- `H_VISIBLE`, `VGA_MODE_H_VISIBLE`, visible columns
- `H_FRONT_PORCH`, `VGA_MODE_H_FRONT_PORCH`, columns after visible before sync
- `H_SYNC_PULSE`, `VGA_MODE_H_SYNC_PULSE`, hsync width in columns
- `H_WHOLE_LINE`, `VGA_MODE_H_WHOLE_LINE`, total columns per line
- `V_VISIBLE`, `V_FRONT_PORCH`, `V_SYNC_PULSE`, `V_WHOLE_FRAME`, `VGA_MODE_V_*`, vertical equivalents in lines
- `H_SYNC_ACTIVE`, 0, hsync level during pulse (0 = active-low)
- `V_SYNC_ACTIVE`, 0, vsync level during pulse
- `PIPELINE_DELAY`, 2, enabled cycles between counter position and the delayed outputs; legal 0..8
- `clk` input 1 pixel clock
- `reset_n` input 1 asynchronous, active-low reset
- `enable` input 1 pixel-clock enable; all state advances only when high
- `column` output `COLUMN_BITS` = `$clog2(H_WHOLE_LINE)`, current fetch column (undelayed)
- `row` output `ROW_BITS` = `$clog2(V_WHOLE_FRAME)`, current fetch row (undelayed)
- `visible` output 1 delayed: pixel in active area
- `hsync` output 1 delayed horizontal sync at configured polarity
- `vsync` output 1 delayed vertical sync at configured polarity
- `vblank` output 1 delayed: row ≥ `V_VISIBLE`
- `line_start` output 1 delayed strobe: column == 0, qualified by `enable`
- `frame_start` output 1 delayed strobe: column == 0 and row == 0, qualified by `enable`

## Operation
- **Column counter:** counts 0..`H_WHOLE_LINE`−1 on each enabled cycle, then wraps to 0.
- **Row counter:** increments on column wrap. At `V_WHOLE_FRAME`−1 with column wrap, the row wraps to 0.
- **Raw decode from counters:**
  - visible = column < `H_VISIBLE` && row < `V_VISIBLE`
  - hsync active for `H_VISIBLE`+`H_FRONT_PORCH` ≤ column < that value + `H_SYNC_PULSE`
  - vsync active for the analogous row range
  - vblank = row ≥ `V_VISIBLE`
  - line_start = column == 0
  - frame_start = line_start && row == 0
- **Delay line:** the raw 6-bit flag vector passes through a `PIPELINE_DELAY`-stage shift register. It shifts only on enabled cycles.
- **Polarity:** applied after the delay. `hsync` = raw_hsync ? `H_SYNC_ACTIVE` : ~`H_SYNC_ACTIVE`; vsync likewise.
- **`PIPELINE_DELAY` = 0:** outputs are combinational from the counters.
- **Strobes:** `line_start` and `frame_start` are ANDed with `enable` at the output, so they are high for exactly one `clk` per event regardless of enable duty cycle.
- **`enable` low:** counters and delay stages hold. `visible`/`hsync`/`vsync`/`vblank` hold their values; strobes are 0.

## Timing
- **Reset (async assert, sync-release-safe):**
  - column = 0, row = 0
  - all delay stages cleared to the inactive vector
  - `visible` = 0, `vblank` = 0, strobes = 0
  - `hsync` = ~`H_SYNC_ACTIVE`, `vsync` = ~`V_SYNC_ACTIVE`
- **After reset:** the first `PIPELINE_DELAY` enabled cycles output the inactive vector, then the position-(0,0) flags appear. The first `frame_start` occurs on enabled cycle number `PIPELINE_DELAY` (0-indexed).
- **Latency:** a counter value presented on enabled cycle N drives the delayed outputs on enabled cycle N+`PIPELINE_DELAY`.
- **Reset mid-frame:** immediate return to reset values. No partial-frame state survives.
- **Widths:** compares are unsigned. All sync boundaries are < `H_WHOLE_LINE` / `V_WHOLE_FRAME`, checked by an elaboration-time `initial` assertion.

## Structure
- **Shared header `vga_mode.v`:** holds the mode constants (`VGA_MODE_*`) and the polarity defaults for the standard 640x480 mode.
- **Sub-module `vga_delay_line`:** parameters `WIDTH`, `DEPTH`, `RESET_VALUE`; ports `clk`, `reset_n`, `enable`, `in`, `out`; `DEPTH` = 0 is a passthrough. It is reused later for pixel data alignment.
- **Counters:** implemented inline. The existing `vga_pixel_addr` is not used, because it has an active-high reset.

## Test plan
- **Reset values** (`H_WHOLE_LINE`=10, `V_WHOLE_FRAME`=6, `H_VISIBLE`=6, `H_FRONT_PORCH`=1, `H_SYNC_PULSE`=2, `V_VISIBLE`=3, `V_FRONT_PORCH`=1, `V_SYNC_PULSE`=1): hold `reset_n`=0 → column=0, row=0, `visible`=0, `hsync`=1, `vsync`=1, strobes 0. Release → first `frame_start` on enabled cycle 2.
- **Counter wrap and sync placement:** continuous enable, `PIPELINE_DELAY`=0 → column 9→0 with row+1; `hsync`=0 exactly at columns 7–8; `vsync`=0 on row 4 only; row 5 col 9 → (0,0).
- **Delay alignment:** `PIPELINE_DELAY`=3 → `hsync` falls 3 enabled cycles after column==7. `visible` rises 3 cycles after (0,0).
- **Enable gating:** `enable` pattern 1,0,0,1 → counters and outputs hold during 0s. `line_start` is high for exactly 1 `clk` per line.
- **Polarity:** `H_SYNC_ACTIVE`=1, `V_SYNC_ACTIVE`=1 → pulses are high, idle low; reset drives both low.
- **Mid-frame reset:** assert `reset_n` at row 2 col 4 asynchronously (between edges) → outputs go to reset values before the next `clk` edge. After release, timing restarts from (0,0).

Source files
------------

// File: rtl/vga_sync_pipe_pkg.sv
// vga_sync_pipe_pkg: 640x480 mode constants and the flag bundle carried down the sync delay line
package vga_sync_pipe_pkg;

   localparam int VGA_MODE_H_VISIBLE     = 640;
   localparam int VGA_MODE_H_FRONT_PORCH = 16;
   localparam int VGA_MODE_H_SYNC_PULSE  = 96;
   localparam int VGA_MODE_H_WHOLE_LINE  = 800;
   localparam int VGA_MODE_V_VISIBLE     = 480;
   localparam int VGA_MODE_V_FRONT_PORCH = 10;
   localparam int VGA_MODE_V_SYNC_PULSE  = 2;
   localparam int VGA_MODE_V_WHOLE_FRAME = 525;
   localparam logic VGA_MODE_H_SYNC_ACTIVE = 1'b0;
   localparam logic VGA_MODE_V_SYNC_ACTIVE = 1'b0;

   // Raw, polarity-free flags; all-zero is the inactive vector.
   typedef struct packed {
      logic frame_start;
      logic line_start;
      logic vblank;
      logic vsync;
      logic hsync;
      logic visible;
   } sync_flags_t;

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: enable-gated shift register of DEPTH stages; DEPTH = 0 is a wire
module vga_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   if (DEPTH == 0) begin : g_pass
      logic unused_ctrl;
      assign unused_ctrl = clk ^ reset_n ^ enable;
      assign out = in;
   end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];
      always_ff @(posedge clk or negedge reset_n)
         if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VALUE;
         end else if (enable) begin
            stage[0] <= in;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
         end
      assign out = stage[DEPTH-1];
   end

endmodule

// File: rtl/vga_sync_pipe.sv
// vga_sync_pipe: VGA column/row counters with sync/blank/strobe flags delayed to match
// the pixel fetch latency, sync polarity applied at the output.
module vga_sync_pipe
   import vga_sync_pipe_pkg::*;
#(
   parameter int H_VISIBLE      = VGA_MODE_H_VISIBLE,
   parameter int H_FRONT_PORCH  = VGA_MODE_H_FRONT_PORCH,
   parameter int H_SYNC_PULSE   = VGA_MODE_H_SYNC_PULSE,
   parameter int H_WHOLE_LINE   = VGA_MODE_H_WHOLE_LINE,
   parameter int V_VISIBLE      = VGA_MODE_V_VISIBLE,
   parameter int V_FRONT_PORCH  = VGA_MODE_V_FRONT_PORCH,
   parameter int V_SYNC_PULSE   = VGA_MODE_V_SYNC_PULSE,
   parameter int V_WHOLE_FRAME  = VGA_MODE_V_WHOLE_FRAME,
   parameter logic H_SYNC_ACTIVE = VGA_MODE_H_SYNC_ACTIVE,
   parameter logic V_SYNC_ACTIVE = VGA_MODE_V_SYNC_ACTIVE,
   parameter int PIPELINE_DELAY = 2,
   parameter int COLUMN_BITS    = $clog2(H_WHOLE_LINE),
   parameter int ROW_BITS       = $clog2(V_WHOLE_FRAME)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   output logic [COLUMN_BITS-1:0] column,
   output logic [ROW_BITS-1:0]    row,
   output logic                   visible,
   output logic                   hsync,
   output logic                   vsync,
   output logic                   vblank,
   output logic                   line_start,
   output logic                   frame_start
);

   localparam int H_SYNC_START = H_VISIBLE + H_FRONT_PORCH;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_PULSE;
   localparam int V_SYNC_START = V_VISIBLE + V_FRONT_PORCH;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_PULSE;

   if (H_SYNC_END > H_WHOLE_LINE || V_SYNC_END > V_WHOLE_FRAME ||
       PIPELINE_DELAY < 0 || PIPELINE_DELAY > 8) begin : g_bad_cfg
      $error("vga_sync_pipe: sync ranges must fit in the line/frame and PIPELINE_DELAY must be 0..8");
   end

   int col_i, row_i;
   logic col_last, row_last;
   sync_flags_t raw, dly;

   assign col_i    = int'(column);
   assign row_i    = int'(row);
   assign col_last = col_i == H_WHOLE_LINE - 1;
   assign row_last = row_i == V_WHOLE_FRAME - 1;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         column <= '0;
         row    <= '0;
      end else if (enable) begin
         column <= col_last ? '0 : column + 1'b1;
         if (col_last) row <= row_last ? '0 : row + 1'b1;
      end

   // Masked while in reset so a zero-depth pipe still shows reset values.
   always_comb begin
      raw = '0;
      if (reset_n) begin
         raw.visible     = col_i < H_VISIBLE && row_i < V_VISIBLE;
         raw.hsync       = col_i >= H_SYNC_START && col_i < H_SYNC_END;
         raw.vsync       = row_i >= V_SYNC_START && row_i < V_SYNC_END;
         raw.vblank      = row_i >= V_VISIBLE;
         raw.line_start  = col_i == 0;
         raw.frame_start = col_i == 0 && row_i == 0;
      end
   end

   vga_delay_line #(
      .WIDTH      ($bits(sync_flags_t)),
      .DEPTH      (PIPELINE_DELAY),
      .RESET_VALUE('0)
   ) u_delay (
      .clk    (clk),
      .reset_n(reset_n),
      .enable (enable),
      .in     (raw),
      .out    (dly)
   );

   assign visible     = dly.visible;
   assign vblank      = dly.vblank;
   assign hsync       = dly.hsync ? H_SYNC_ACTIVE : ~H_SYNC_ACTIVE;
   assign vsync       = dly.vsync ? V_SYNC_ACTIVE : ~V_SYNC_ACTIVE;
   assign line_start  = dly.line_start & enable;
   assign frame_start = dly.frame_start & enable;

endmodule

// File: tb/tb_vga_sync_pipe.sv
// tb_vga_sync_pipe: small 10x6 mode at four delay/polarity settings, checked against a
// position-arithmetic model plus a hand-computed table for the first cycles.
module tb_vga_sync_pipe;

   localparam int HW = 10, VW = 6;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic enable = 1'b1;
   logic [3:0] col [4];
   logic [2:0] row [4];
   logic vis [4], hs [4], vs [4], vb [4], ls [4], fs [4];

   int checks = 0;
   int errors = 0;
   int k = 0;
   int dly_of [4] = '{2, 0, 3, 1};
   bit pol_of [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

   always #5 clk = ~clk;

   vga_sync_pipe #(.H_VISIBLE(6), .H_FRONT_PORCH(1), .H_SYNC_PULSE(2), .H_WHOLE_LINE(HW),
      .V_VISIBLE(3), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_WHOLE_FRAME(VW),
      .H_SYNC_ACTIVE(1'b0), .V_SYNC_ACTIVE(1'b0), .PIPELINE_DELAY(2)) u0 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .column(col[0]), .row(row[0]),
      .visible(vis[0]), .hsync(hs[0]), .vsync(vs[0]), .vblank(vb[0]),
      .line_start(ls[0]), .frame_start(fs[0]));

   vga_sync_pipe #(.H_VISIBLE(6), .H_FRONT_PORCH(1), .H_SYNC_PULSE(2), .H_WHOLE_LINE(HW),
      .V_VISIBLE(3), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_WHOLE_FRAME(VW),
      .H_SYNC_ACTIVE(1'b0), .V_SYNC_ACTIVE(1'b0), .PIPELINE_DELAY(0)) u1 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .column(col[1]), .row(row[1]),
      .visible(vis[1]), .hsync(hs[1]), .vsync(vs[1]), .vblank(vb[1]),
      .line_start(ls[1]), .frame_start(fs[1]));

   vga_sync_pipe #(.H_VISIBLE(6), .H_FRONT_PORCH(1), .H_SYNC_PULSE(2), .H_WHOLE_LINE(HW),
      .V_VISIBLE(3), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_WHOLE_FRAME(VW),
      .H_SYNC_ACTIVE(1'b0), .V_SYNC_ACTIVE(1'b0), .PIPELINE_DELAY(3)) u2 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .column(col[2]), .row(row[2]),
      .visible(vis[2]), .hsync(hs[2]), .vsync(vs[2]), .vblank(vb[2]),
      .line_start(ls[2]), .frame_start(fs[2]));

   vga_sync_pipe #(.H_VISIBLE(6), .H_FRONT_PORCH(1), .H_SYNC_PULSE(2), .H_WHOLE_LINE(HW),
      .V_VISIBLE(3), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_WHOLE_FRAME(VW),
      .H_SYNC_ACTIVE(1'b1), .V_SYNC_ACTIVE(1'b1), .PIPELINE_DELAY(1)) u3 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .column(col[3]), .row(row[3]),
      .visible(vis[3]), .hsync(hs[3]), .vsync(vs[3]), .vblank(vb[3]),
      .line_start(ls[3]), .frame_start(fs[3]));

   // Expected {column,row,visible,hsync,vsync,vblank,line_start,frame_start} after n enabled
   // cycles since reset: counters show position n, flags describe position n-d.
   function automatic logic [12:0] model(input int n, input int d, input bit pol,
                                         input bit en, input bit in_rst);
      int p, c, r, q, qc, qr;
      logic fv, fh, fvs, fb, fl, ff;
      p = in_rst ? 0 : n % (HW * VW);
      c = p % HW;
      r = p / HW;
      {fv, fh, fvs, fb, fl, ff} = '0;
      if (!in_rst && n >= d) begin
         q   = (n - d) % (HW * VW);
         qc  = q % HW;
         qr  = q / HW;
         fv  = qc < 6 && qr < 3;
         fh  = qc >= 7 && qc <= 8;
         fvs = qr == 4;
         fb  = qr >= 3;
         fl  = qc == 0;
         ff  = qc == 0 && qr == 0;
      end
      return {4'(c), 3'(r), fv, fh ? pol : ~pol, fvs ? pol : ~pol, fb, fl & en, ff & en};
   endfunction

   function automatic logic [12:0] dut_vec(input int i);
      return {col[i], row[i], vis[i], hs[i], vs[i], vb[i], ls[i], fs[i]};
   endfunction

   task automatic cmp(input string name, input logic [12:0] act, input logic [12:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (k=%0d t=%0t)", name, act, exp, k, $time);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 4; i++)
         cmp($sformatf("model_u%0d", i), dut_vec(i),
             model(k, dly_of[i], pol_of[i], enable, !reset_n));
   endtask

   task automatic step(input bit rn, input bit en);
      @(negedge clk);
      reset_n = rn;
      enable  = en;
      if (!rn) k = 0;
      #1 check_all();
      @(posedge clk);
      if (reset_n && enable) k++;
   endtask

   typedef struct {
      logic rn, en;
      logic [3:0] c;
      logic [2:0] r;
      logic v, h, s, b, l, f;
   } vec_t;

   vec_t tv [18];

   initial begin
      int n;
      tv[0]  = '{0, 1, 0, 0, 0, 1, 1, 0, 0, 0};
      tv[1]  = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
      tv[2]  = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 0};
      tv[3]  = '{1, 1, 2, 0, 1, 1, 1, 0, 1, 1};
      tv[4]  = '{1, 0, 3, 0, 1, 1, 1, 0, 0, 0};
      tv[5]  = '{1, 0, 3, 0, 1, 1, 1, 0, 0, 0};
      tv[6]  = '{1, 1, 3, 0, 1, 1, 1, 0, 0, 0};
      tv[7]  = '{1, 1, 4, 0, 1, 1, 1, 0, 0, 0};
      tv[8]  = '{1, 1, 5, 0, 1, 1, 1, 0, 0, 0};
      tv[9]  = '{1, 1, 6, 0, 1, 1, 1, 0, 0, 0};
      tv[10] = '{1, 1, 7, 0, 1, 1, 1, 0, 0, 0};
      tv[11] = '{1, 1, 8, 0, 0, 1, 1, 0, 0, 0};
      tv[12] = '{1, 1, 9, 0, 0, 0, 1, 0, 0, 0};
      tv[13] = '{1, 1, 0, 1, 0, 0, 1, 0, 0, 0};
      tv[14] = '{1, 1, 1, 1, 0, 1, 1, 0, 0, 0};
      tv[15] = '{1, 0, 2, 1, 1, 1, 1, 0, 0, 0};
      tv[16] = '{1, 1, 2, 1, 1, 1, 1, 0, 1, 0};
      tv[17] = '{1, 1, 3, 1, 1, 1, 1, 0, 0, 0};

      foreach (tv[i]) begin
         @(negedge clk);
         reset_n = tv[i].rn;
         enable  = tv[i].en;
         if (!tv[i].rn) k = 0;
         #1;
         cmp($sformatf("table_%0d", i), dut_vec(0),
             {tv[i].c, tv[i].r, tv[i].v, tv[i].h, tv[i].s, tv[i].b, tv[i].l, tv[i].f});
         check_all();
         @(posedge clk);
         if (reset_n && enable) k++;
      end

      repeat (300) step(1'b1, 1'b1);
      repeat (1200) step(1'b1, $urandom_range(0, 3) != 0);

      // Walk to row 2 column 4, then pull reset between clock edges.
      n = 0;
      while (k % (HW * VW) != 24 && n < 200) begin
         step(1'b1, 1'b1);
         n++;
      end
      cmp("reach_row2_col4", {4'(k % HW), 3'((k / HW) % VW)}, {4'd4, 3'd2});
      #3;
      reset_n = 1'b0;
      k = 0;
      #1;
      check_all();
      cmp("midframe_reset_u0", dut_vec(0), 13'b0000_000_0_1_1_0_0_0);
      cmp("midframe_reset_u3", dut_vec(3), 13'b0000_000_0_0_0_0_0_0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      repeat (400) step(1'b1, $urandom_range(0, 4) != 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
